// File: rtl/gpr_file_param.sv
// Parameterised general-purpose register file with two registered read ports,
// per-register pending (busy) tracking, optional write forwarding and a bulk-clear sweep.
module gpr_file_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            read_en,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            write_en,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] write_data,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  input  logic            clr_req,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            ready,
  output logic            clr_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t            state_r, state_s;
  logic [AW-1:0]     idx_r, idx_s;
  logic              ready_r, clr_done_r;
  logic [XLEN-1:0]   regs_r [NREGS];
  logic [NREGS-1:0]  busy_r;
  logic              rd_ok_s, wr_ok_s, rsv_ok_s;
  logic [XLEN:0]     rs1_mux_s, rs2_mux_s;
  logic [XLEN-1:0]   rs1_data_r, rs2_data_r;
  logic              rs1_busy_r, rs2_busy_r;

  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return (ZERO_REG != 32'sd0) && (addr == ZERO_IDX);
  endfunction

  // Read mux result is {busy, data}; forwarding only applies when a write is actually accepted.
  function automatic logic [XLEN:0] read_mux(
    input logic [AW-1:0]   addr,
    input logic [XLEN-1:0] stored,
    input logic            stored_busy,
    input logic            wr_ok,
    input logic [AW-1:0]   wr_addr,
    input logic [XLEN-1:0] wr_data
  );
    logic [XLEN:0] res;
    if (is_zero_reg(addr)) begin
      res = {1'b0, {XLEN{1'b0}}};
    end else if ((BYPASS != 32'sd0) && wr_ok && (wr_addr == addr)) begin
      res = {1'b0, wr_data};
    end else begin
      res = {stored_busy, stored};
    end
    return res;
  endfunction

  // Strobe qualification: nothing is accepted while the sweep owns the array.
  always_comb begin
    rd_ok_s  = read_en & ready_r;
    wr_ok_s  = write_en & ready_r & ~is_zero_reg(rd_addr);
    rsv_ok_s = rsv_en & ready_r & ~is_zero_reg(rsv_addr);
  end

  // Next-state and clear-index logic for the bulk-clear sequencer.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        idx_s = ZERO_IDX;
        if (clr_req) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (idx_r == LAST_IDX) begin
          state_s = ST_DONE;
          idx_s   = ZERO_IDX;
        end else begin
          state_s = ST_CLEAR;
          idx_s   = idx_r + AW'(1'b1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        idx_s   = ZERO_IDX;
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = ZERO_IDX;
      end
    endcase
  end

  // Sequencer state, index and the registered ready/clr_done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= ZERO_IDX;
      ready_r    <= 1'b1;
      clr_done_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      ready_r    <= (state_s == ST_IDLE);
      clr_done_r <= (state_s == ST_DONE);
    end
  end

  // Register array and busy bits; reservation is applied last so it wins over a same-address write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
      busy_r <= {NREGS{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      regs_r[idx_r] <= {XLEN{1'b0}};
      busy_r[idx_r] <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        regs_r[rd_addr] <= write_data;
        busy_r[rd_addr] <= 1'b0;
      end
      if (rsv_ok_s) begin
        busy_r[rsv_addr] <= 1'b1;
      end
    end
  end

  // Combinational read selection for both ports.
  always_comb begin
    rs1_mux_s = read_mux(rs1_addr, regs_r[rs1_addr], busy_r[rs1_addr], wr_ok_s, rd_addr, write_data);
    rs2_mux_s = read_mux(rs2_addr, regs_r[rs2_addr], busy_r[rs2_addr], wr_ok_s, rd_addr, write_data);
  end

  // Registered read ports; they hold whenever no qualified read is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_data_r <= {XLEN{1'b0}};
      rs2_data_r <= {XLEN{1'b0}};
      rs1_busy_r <= 1'b0;
      rs2_busy_r <= 1'b0;
    end else if (rd_ok_s) begin
      rs1_data_r <= rs1_mux_s[XLEN-1:0];
      rs2_data_r <= rs2_mux_s[XLEN-1:0];
      rs1_busy_r <= rs1_mux_s[XLEN];
      rs2_busy_r <= rs2_mux_s[XLEN];
    end
  end

  assign rs1_data = rs1_data_r;
  assign rs2_data = rs2_data_r;
  assign rs1_busy = rs1_busy_r;
  assign rs2_busy = rs2_busy_r;
  assign ready    = ready_r;
  assign clr_done = clr_done_r;

endmodule

// File: tb/tb_gpr_file_param.sv
// Directed self-checking bench for gpr_file_param with default parameters.
module tb_gpr_file_param;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk        = 1'b0;
  logic            rst_n      = 1'b1;
  logic            read_en    = 1'b0;
  logic [AW-1:0]   rs1_addr   = '0;
  logic [AW-1:0]   rs2_addr   = '0;
  logic            write_en   = 1'b0;
  logic [AW-1:0]   rd_addr    = '0;
  logic [XLEN-1:0] write_data = '0;
  logic            rsv_en     = 1'b0;
  logic [AW-1:0]   rsv_addr   = '0;
  logic            clr_req    = 1'b0;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rs1_busy, rs2_busy, ready, clr_done;

  int n_cmp = 0;
  int n_bad = 0;

  gpr_file_param #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .write_en(write_en), .rd_addr(rd_addr), .write_data(write_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .clr_req(clr_req), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .ready(ready), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_en = 1'b0; write_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
  endtask

  function automatic logic [31:0] fill(input int i);
    return 32'hA5A50000 | 32'(i);
  endfunction

  task automatic test_reset();
    idle();
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL rst_rs1_data got %h want %h", rs1_data, 32'h0); end
    n_cmp++; if (rs2_data !== 32'h0) begin n_bad++; $display("FAIL rst_rs2_data got %h want %h", rs2_data, 32'h0); end
    n_cmp++; if ({rs1_busy, rs2_busy, clr_done} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b want 000", {rs1_busy, rs2_busy, clr_done}); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", ready); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready got %b want 1", ready); end
  endtask

  task automatic test_write_read();
    write_en = 1'b1; rd_addr = 5'd5; write_data = 32'hDEADBEEF;
    tick();
    idle(); read_en = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd6;
    tick();
    idle();
    n_cmp++; if (rs1_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_rd_rs1 got %h want %h", rs1_data, 32'hDEADBEEF); end
    n_cmp++; if (rs1_busy !== 1'b0) begin n_bad++; $display("FAIL wr_rd_busy got %b want 0", rs1_busy); end
    n_cmp++; if (rs2_data !== 32'h0) begin n_bad++; $display("FAIL wr_rd_rs2 got %h want %h", rs2_data, 32'h0); end
  endtask

  task automatic test_bypass();
    write_en = 1'b1; rd_addr = 5'd7; write_data = 32'h11110000;
    tick();
    idle(); rsv_en = 1'b1; rsv_addr = 5'd7;
    tick();
    idle(); write_en = 1'b1; rd_addr = 5'd7; write_data = 32'h12345678;
    read_en = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd7;
    tick();
    idle();
    n_cmp++; if (rs2_data !== 32'h12345678) begin n_bad++; $display("FAIL byp_data got %h want %h", rs2_data, 32'h12345678); end
    n_cmp++; if (rs2_busy !== 1'b0) begin n_bad++; $display("FAIL byp_busy got %b want 0", rs2_busy); end
    n_cmp++; if (rs1_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL byp_nomatch got %h want %h", rs1_data, 32'hDEADBEEF); end
    read_en = 1'b1; rs1_addr = 5'd7;
    tick();
    idle();
    n_cmp++; if ({rs1_busy, rs1_data} !== {1'b0, 32'h12345678}) begin n_bad++; $display("FAIL byp_stored got %b/%h want 0/%h", rs1_busy, rs1_data, 32'h12345678); end
  endtask

  task automatic test_zero_reg();
    write_en = 1'b1; rd_addr = 5'd0; write_data = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    read_en = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd0;
    tick();
    idle();
    n_cmp++; if ({rs1_busy, rs1_data} !== 33'h0) begin n_bad++; $display("FAIL x0_same_cycle got %b/%h want 0/0", rs1_busy, rs1_data); end
    read_en = 1'b1;
    tick();
    idle();
    n_cmp++; if ({rs1_busy, rs1_data} !== 33'h0) begin n_bad++; $display("FAIL x0_rs1 got %b/%h want 0/0", rs1_busy, rs1_data); end
    n_cmp++; if ({rs2_busy, rs2_data} !== 33'h0) begin n_bad++; $display("FAIL x0_rs2 got %b/%h want 0/0", rs2_busy, rs2_data); end
  endtask

  task automatic test_reserve();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    idle(); read_en = 1'b1; rs1_addr = 5'd3;
    tick();
    idle();
    n_cmp++; if ({rs1_busy, rs1_data} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL rsv_busy got %b/%h want 1/0", rs1_busy, rs1_data); end
    rsv_en = 1'b1; rsv_addr = 5'd3; write_en = 1'b1; rd_addr = 5'd3; write_data = 32'hCAFEF00D;
    tick();
    idle(); read_en = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd3;
    tick();
    idle();
    n_cmp++; if ({rs1_busy, rs1_data} !== {1'b1, 32'hCAFEF00D}) begin n_bad++; $display("FAIL rsv_wins got %b/%h want 1/%h", rs1_busy, rs1_data, 32'hCAFEF00D); end
    write_en = 1'b1; rd_addr = 5'd3; write_data = 32'h00000001;
    tick();
    idle(); read_en = 1'b1;
    tick();
    idle();
    n_cmp++; if ({rs2_busy, rs2_data} !== {1'b0, 32'h1}) begin n_bad++; $display("FAIL wr_clears_busy got %b/%h want 0/1", rs2_busy, rs2_data); end
  endtask

  task automatic test_hold();
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    tick();
    n_cmp++; if ({rs1_data, rs2_data} !== {32'h1, 32'h1}) begin n_bad++; $display("FAIL hold got %h/%h want 1/1", rs1_data, rs2_data); end
  endtask

  task automatic test_clear();
    int low;
    int dn;
    for (int i = 1; i < NREGS; i++) begin
      write_en = 1'b1; rd_addr = AW'(i); write_data = fill(i);
      rsv_en = 1'b1; rsv_addr = 5'd12;
      tick();
    end
    idle();
    clr_req = 1'b1; write_en = 1'b1; rd_addr = 5'd9; write_data = 32'h00000099;
    read_en = 1'b1; rs1_addr = 5'd31; rs2_addr = 5'd9;
    tick();
    n_cmp++; if (rs1_data !== fill(31)) begin n_bad++; $display("FAIL clr_pre_rs1 got %h want %h", rs1_data, fill(31)); end
    n_cmp++; if (rs2_data !== 32'h99) begin n_bad++; $display("FAIL clr_req_write got %h want %h", rs2_data, 32'h99); end
    low = (ready === 1'b0) ? 1 : 0;
    dn  = 0;
    rs1_addr = 5'd5; rs2_addr = 5'd12;
    write_en = 1'b1; rd_addr = 5'd4; write_data = 32'h00000044;
    rsv_en = 1'b1; rsv_addr = 5'd4;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (clr_done === 1'b1) dn++;
      if (ready === 1'b1) break;
      low++;
    end
    idle();
    n_cmp++; if (low !== NREGS + 1) begin n_bad++; $display("FAIL clr_ready_low got %0d want %0d", low, NREGS + 1); end
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL clr_done_pulses got %0d want 1", dn); end
    n_cmp++; if (rs1_data !== fill(31)) begin n_bad++; $display("FAIL clr_hold got %h want %h", rs1_data, fill(31)); end
    for (int i = 0; i < NREGS; i++) begin
      read_en = 1'b1; rs1_addr = AW'(i); rs2_addr = AW'(NREGS - 1 - i);
      tick();
      n_cmp++; if ({rs1_busy, rs1_data, rs2_busy, rs2_data} !== 66'h0) begin
        n_bad++; $display("FAIL clr_read_x%0d got %b/%h %b/%h want zeros", i, rs1_busy, rs1_data, rs2_busy, rs2_data);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    write_en = 1'b1; rd_addr = 5'd20; write_data = 32'hDEADBEEF;
    tick();
    idle(); rsv_en = 1'b1; rsv_addr = 5'd21;
    tick();
    idle(); read_en = 1'b1; rs1_addr = 5'd20; rs2_addr = 5'd21;
    tick();
    idle();
    n_cmp++; if ({rs1_data, rs2_busy} !== {32'hDEADBEEF, 1'b1}) begin n_bad++; $display("FAIL mid_pre got %h/%b want deadbeef/1", rs1_data, rs2_busy); end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_clearing got %b want 0", ready); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready got %b want 1", ready); end
    n_cmp++; if ({rs1_data, rs2_data, rs1_busy, rs2_busy, clr_done} !== 67'h0) begin
      n_bad++; $display("FAIL mid_rst_outputs got %h %h %b %b %b want zeros", rs1_data, rs2_data, rs1_busy, rs2_busy, clr_done);
    end
    tick();
    rst_n = 1'b1;
    read_en = 1'b1; rs1_addr = 5'd20; rs2_addr = 5'd21;
    tick();
    idle();
    n_cmp++; if ({rs1_data, rs2_busy, ready} !== {32'h0, 1'b0, 1'b1}) begin n_bad++; $display("FAIL mid_after got %h/%b/%b want 0/0/1", rs1_data, rs2_busy, ready); end
    write_en = 1'b1; rd_addr = 5'd2; write_data = 32'h22222222;
    tick();
    idle(); read_en = 1'b1; rs1_addr = 5'd2;
    tick();
    idle();
    n_cmp++; if (rs1_data !== 32'h22222222) begin n_bad++; $display("FAIL mid_resume got %h want %h", rs1_data, 32'h22222222); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_reserve();
    test_hold();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gpr_file_param.md
GPR_FILE_PARAM -- requirements
Module: gpr_file_param

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width in bits.
REQ-002 SHALL provide parameter NREGS, default 32, register count (power of 2, 2..64).
REQ-003 SHALL provide parameter AW, default 5, address width equal to log2(NREGS).
REQ-004 SHALL provide parameter ZERO_REG, default 1: 1 = index 0 hardwired to zero.
REQ-005 SHALL provide parameter BYPASS, default 1: 1 = write-to-read forwarding enabled.
REQ-006 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  system clock; rst_n  in  1  async active-low reset.
REQ-007 SHALL provide ports:
  read_en  in  1  read strobe, both ports;
  rs1_addr  in  AW  read port 1 address;
  rs2_addr  in  AW  read port 2 address;
  write_en  in  1  writeback strobe;
  rd_addr  in  AW  writeback address;
  write_data  in  XLEN  writeback data;
  rsv_en  in  1  reserve (mark pending) strobe;
  rsv_addr  in  AW  address to reserve;
  clr_req  in  1  start bulk-clear pulse;
  rs1_data  out  XLEN  registered read data, port 1;
  rs2_data  out  XLEN  registered read data, port 2;
  rs1_busy  out  1  registered pending flag, port 1;
  rs2_busy  out  1  registered pending flag, port 2;
  ready  out  1  high when not clearing;
  clr_done  out  1  one-cycle pulse at end of clear.

Function
REQ-008 SHALL register reads: when read_en && ready, rsN_data and rsN_busy update on the next clk edge (latency 1); otherwise they hold.
REQ-009 SHALL, when ZERO_REG=1, return 0 and busy=0 for address 0, ignore writes to 0 and ignore reservations of 0.
REQ-010 SHALL, when BYPASS=1, forward write_data and return busy=0 on port N if write_en && rd_addr==rsN_addr (and address != 0 when ZERO_REG=1) in the same cycle as read_en.
REQ-011 SHALL, when BYPASS=0, return the pre-write stored value and busy flag on a same-cycle address match.
REQ-012 SHALL keep one busy bit per register: rsv_en sets busy[rsv_addr]; write_en clears busy[rd_addr].
REQ-013 SHALL, on simultaneous rsv_en and write_en to the same address, write the data and leave busy set (reserve wins).
REQ-014 SHALL implement FSM IDLE -> CLEAR -> DONE -> IDLE.
REQ-015 SHALL enter CLEAR from IDLE when clr_req=1, with index counter=0.
REQ-016 SHALL, in CLEAR, zero register[index] and busy[index] each cycle and increment index; it SHALL go to DONE after index NREGS-1 (NREGS cycles total).
REQ-017 SHALL, in DONE, assert clr_done for exactly one cycle and return to IDLE.
REQ-018 SHALL drive ready=0 in CLEAR and DONE, and ready=1 in IDLE.
REQ-019 SHALL, while ready=0, ignore write_en, rsv_en and read_en, and hold the outputs.
REQ-020 SHALL ignore clr_req outside IDLE.
REQ-021 SHALL, on an IDLE cycle where clr_req and write_en are both asserted, perform the write; the write is then zeroed by the sweep.
REQ-022 SHALL wrap the clear index at NREGS-1 without overflow into unused counter states.

Reset
REQ-023 SHALL, on rst_n=0 (asynchronous, at any time including mid-CLEAR), zero all registers, busy bits, rs1_data, rs2_data, rs1_busy, rs2_busy, clr_done and the index, and force the FSM to IDLE.
REQ-024 SHALL hold ready=1 during and after reset.
REQ-025 SHALL resume normal operation on the first clk edge after rst_n deasserts.

Verification
REQ-026 Write x5=0xDEADBEEF, then next cycle read rs1=5 -> rs1_data=0xDEADBEEF one cycle later.
REQ-027 Same cycle: write x7=0x12345678 and read rs2=7 -> with BYPASS=1, rs2_data=0x12345678 and rs2_busy=0; with BYPASS=0, rs2_data equals the old value.
REQ-028 Write x0=0xFFFFFFFF, reserve x0, read rs1=0 -> rs1_data=0 and rs1_busy=0.
REQ-029 Reserve x3, read -> rs1_busy=1; then same-cycle rsv_en and write_en on x3 -> data written and busy stays 1.
REQ-030 Fill all registers, pulse clr_req -> ready=0 for NREGS+1 cycles, clr_done pulses once, all reads return 0.
REQ-031 Assert rst_n=0 mid-CLEAR (index=10) -> immediate IDLE, ready=1, all outputs 0.
